// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer for uart_ip.
// Captures every completed receiver byte with its parity-error flag in a
// first-word-fall-through FIFO and reports level, threshold, overrun and
// character-timeout status to the register interface.
//
// Handshake: the receiver side has no back-pressure. recv_valid is a
// one-cycle strobe and the byte is accepted at that edge unless the FIFO is
// full with no pop in the same cycle, in which case the byte is dropped and
// ovr is set. On the read side, rd_data/rd_perr are valid whenever
// empty=0 and rd_en is the pop strobe; rd_en while empty is ignored.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int DW    = 8,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          arst,
    input  logic          recv_valid,
    input  logic [DW-1:0] recv_data,
    input  logic          recv_perr,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          rd_perr,
    output logic          empty,
    output logic          full,
    output logic [LW-1:0] level,
    input  logic [LW-1:0] thresh,
    output logic          thresh_hit,
    output logic          ovr,
    input  logic          ovr_clr,
    input  logic [23:0]   tmo_cycles,
    output logic          tmo
);

    localparam int PW = $clog2(DEPTH);

    // Storage: entry = {perr, data}; contents are intentionally not reset.
    logic [DW:0]     mem_q [DEPTH];
    logic [DW:0]     head;

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic            ovr_q, ovr_d;
    logic [23:0]     tmo_cnt_q, tmo_cnt_d;
    logic            tmo_q, tmo_d;

    logic            push;
    logic            pop;
    logic            overflow;

    // Status is derived only from the registered level.
    assign empty      = (level_q == '0);
    assign full       = (level_q == LW'(DEPTH));
    assign level      = level_q;
    assign thresh_hit = (level_q >= thresh);
    assign ovr        = ovr_q;
    assign tmo        = tmo_q;

    // A pop into an empty FIFO is ignored; a full FIFO still accepts a byte
    // when the same cycle also pops, so that case never overruns.
    assign pop      = rd_en & ~empty;
    assign push     = recv_valid & (~full | rd_en);
    assign overflow = recv_valid & full & ~rd_en;

    // Fall-through read: head entry depends only on the registered read pointer.
    assign head    = mem_q[rd_ptr_q];
    assign rd_data = head[DW-1:0];
    assign rd_perr = head[DW];

    // Write accepted bytes into the array at the write pointer.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {recv_perr, recv_data};
        end
    end

    // Next-state for pointers, level and the sticky overrun flag.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovr_d    = ovr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        // Overflow and clear in the same cycle: the new overflow wins.
        if (overflow) begin
            ovr_d = 1'b1;
        end else if (ovr_clr) begin
            ovr_d = 1'b0;
        end
    end

    // Next-state for the character-timeout counter and sticky tmo flag.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        tmo_d     = tmo_q;
        if (push || pop || empty || (tmo_cycles == 24'd0)) begin
            tmo_cnt_d = 24'd0;
        end else if (tmo_cnt_q >= tmo_cycles) begin
            // Saturate; also pulls the count down if tmo_cycles was lowered.
            tmo_cnt_d = tmo_cycles;
        end else begin
            tmo_cnt_d = tmo_cnt_q + 24'd1;
        end
        // Comparing with >= makes a lowered tmo_cycles fire on the next edge.
        if (pop || empty) begin
            tmo_d = 1'b0;
        end else if (!push && (tmo_cycles != 24'd0) &&
                     (tmo_cnt_q >= tmo_cycles - 24'd1)) begin
            tmo_d = 1'b1;
        end
    end

    // State registers; asynchronous reset clears everything except memory.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            ovr_q     <= 1'b0;
            tmo_cnt_q <= 24'd0;
            tmo_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            ovr_q     <= ovr_d;
            tmo_cnt_q <= tmo_cnt_d;
            tmo_q     <= tmo_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios followed by randomized traffic,
// all checked every cycle against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int DW    = 8;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          arst = 1'b1;
    logic          recv_valid = 1'b0;
    logic [DW-1:0] recv_data = '0;
    logic          recv_perr = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_perr;
    logic          empty;
    logic          full;
    logic [LW-1:0] level;
    logic [LW-1:0] thresh = '0;
    logic          thresh_hit;
    logic          ovr;
    logic          ovr_clr = 1'b0;
    logic [23:0]   tmo_cycles = 24'd0;
    logic          tmo;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [DW:0] exp_q[$];
    logic        m_ovr = 1'b0;
    logic        m_tmo = 1'b0;
    int          m_idle = 0;

    uart_rx_fifo #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk        (clk),
        .arst       (arst),
        .recv_valid (recv_valid),
        .recv_data  (recv_data),
        .recv_perr  (recv_perr),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_perr    (rd_perr),
        .empty      (empty),
        .full       (full),
        .level      (level),
        .thresh     (thresh),
        .thresh_hit (thresh_hit),
        .ovr        (ovr),
        .ovr_clr    (ovr_clr),
        .tmo_cycles (tmo_cycles),
        .tmo        (tmo)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_ovr  = 1'b0;
        m_tmo  = 1'b0;
        m_idle = 0;
    endtask

    // Advance the model by one clock edge using the inputs held during it.
    task automatic model_step();
        bit m_empty, m_full, m_push, m_pop, m_over;
        int tc;
        if (arst) begin
            model_reset();
            return;
        end
        m_empty = (exp_q.size() == 0);
        m_full  = (exp_q.size() == DEPTH);
        m_pop   = rd_en && !m_empty;
        m_push  = recv_valid && (!m_full || rd_en);
        m_over  = recv_valid && m_full && !rd_en;
        tc      = int'(tmo_cycles);
        // Idle-time tracking: counts non-empty cycles without traffic, capped at tc.
        if (m_push || m_pop || m_empty || tc == 0) begin
            m_idle = 0;
        end else begin
            if (m_idle + 1 >= tc) m_tmo = 1'b1;
            m_idle = (m_idle + 1 > tc) ? tc : m_idle + 1;
        end
        if (m_pop || m_empty) m_tmo = 1'b0;
        if (m_over) m_ovr = 1'b1;
        else if (ovr_clr) m_ovr = 1'b0;
        if (m_pop) void'(exp_q.pop_front());
        if (m_push) exp_q.push_back({recv_perr, recv_data});
    endtask

    task automatic check_all();
        logic [DW:0] h;
        check("level", 32'(level), 32'(exp_q.size()));
        check("empty", 32'(empty), 32'(exp_q.size() == 0));
        check("full", 32'(full), 32'(exp_q.size() == DEPTH));
        check("thresh_hit", 32'(thresh_hit), 32'(exp_q.size() >= int'(thresh)));
        check("ovr", 32'(ovr), 32'(m_ovr));
        check("tmo", 32'(tmo), 32'(m_tmo));
        if (exp_q.size() > 0) begin
            h = exp_q[0];
            check("rd_data", 32'(rd_data), 32'(h[DW-1:0]));
            check("rd_perr", 32'(rd_perr), 32'(h[DW]));
        end
    endtask

    // One clock: model follows the edge, outputs sampled 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic drive(input bit v, input logic [DW-1:0] d, input bit p, input bit r);
        recv_valid = v;
        recv_data  = d;
        recv_perr  = p;
        rd_en      = r;
        cycle();
        recv_valid = 1'b0;
        rd_en      = 1'b0;
    endtask

    task automatic push_byte(input logic [DW-1:0] d, input bit p);
        drive(1'b1, d, p, 1'b0);
    endtask

    task automatic pop_one();
        drive(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        // Reset
        arst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        arst = 1'b0;
        check_all();
        idle(3);
        check("reset_thresh_hit", 32'(thresh_hit), 32'd1);

        // Two bytes, then two pops
        push_byte(8'h5A, 1'b0);
        push_byte(8'h13, 1'b1);
        check("two_level", 32'(level), 32'd2);
        check("two_head", 32'(rd_data), 32'h5A);
        pop_one();
        check("two_second", 32'({rd_perr, rd_data}), 32'h113);
        pop_one();
        check("two_empty", 32'(empty), 32'd1);

        // Fill, overflow, drain, clear
        for (int i = 0; i < DEPTH; i++) push_byte(DW'(i), 1'b0);
        push_byte(8'hFF, 1'b0);
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_ovr", 32'(ovr), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_order", 32'(rd_data), 32'(i));
            pop_one();
        end
        check("drain_empty", 32'(empty), 32'd1);
        ovr_clr = 1'b1;
        cycle();
        ovr_clr = 1'b0;
        check("ovr_cleared", 32'(ovr), 32'd0);

        // Push+pop when full, then when empty
        for (int i = 0; i < DEPTH; i++) push_byte(DW'(8'h20 + i), 1'b0);
        drive(1'b1, 8'hAB, 1'b1, 1'b1);
        check("pp_full_level", 32'(level), 32'd16);
        check("pp_full_ovr", 32'(ovr), 32'd0);
        for (int i = 0; i < DEPTH - 1; i++) pop_one();
        check("pp_full_last", 32'({rd_perr, rd_data}), 32'h1AB);
        pop_one();
        drive(1'b1, 8'h77, 1'b0, 1'b1);
        check("pp_empty_level", 32'(level), 32'd1);
        check("pp_empty_data", 32'(rd_data), 32'h77);
        pop_one();

        // Threshold
        thresh = LW'(4);
        for (int i = 0; i < 3; i++) push_byte(DW'($urandom), 1'b0);
        check("thr_below", 32'(thresh_hit), 32'd0);
        push_byte(DW'($urandom), 1'b1);
        check("thr_at", 32'(thresh_hit), 32'd1);
        pop_one();
        check("thr_after_pop", 32'(thresh_hit), 32'd0);
        for (int i = 0; i < 3; i++) pop_one();
        thresh = '0;

        // Character timeout
        tmo_cycles = 24'd100;
        push_byte(8'h42, 1'b0);
        for (int i = 1; i < 100; i++) begin
            cycle();
            check("tmo_early", 32'(tmo), 32'd0);
        end
        cycle();
        check("tmo_exact", 32'(tmo), 32'd1);
        pop_one();
        check("tmo_pop_clear", 32'(tmo), 32'd0);
        tmo_cycles = 24'd0;
        push_byte(8'h43, 1'b0);
        for (int i = 0; i < 1000; i++) begin
            cycle();
            check("tmo_disabled", 32'(tmo), 32'd0);
        end
        // Lowering tmo_cycles below the current idle time fires on the next edge
        tmo_cycles = 24'd50;
        idle(30);
        tmo_cycles = 24'd10;
        cycle();
        check("tmo_lowered", 32'(tmo), 32'd1);
        pop_one();

        // Reset in the middle of traffic; a byte offered during reset is dropped
        for (int i = 0; i < 5; i++) push_byte(DW'($urandom), 1'b0);
        arst = 1'b1;
        recv_valid = 1'b1;
        recv_data  = 8'h99;
        #1;
        check("arst_async_level", 32'(level), 32'd0);
        cycle();
        recv_valid = 1'b0;
        arst = 1'b0;
        idle(2);

        // Randomized traffic in phases of differing write/read pressure
        for (int ph = 0; ph < 6; ph++) begin
            int pw, pr;
            pw = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 30 : 50;
            pr = (ph % 3 == 0) ? 20 : (ph % 3 == 1) ? 70 : 50;
            for (int c = 0; c < 500; c++) begin
                if (c % 100 == 0) begin
                    tmo_cycles = 24'($urandom_range(0, 30));
                    thresh     = LW'($urandom_range(0, DEPTH));
                end
                recv_valid = ($urandom_range(0, 99) < pw);
                recv_data  = DW'($urandom);
                recv_perr  = ($urandom_range(0, 7) == 0);
                rd_en      = ($urandom_range(0, 99) < pr) && ($urandom_range(0, 3) != 0);
                ovr_clr    = ($urandom_range(0, 31) == 0);
                cycle();
            end
        end
        recv_valid = 1'b0;
        rd_en      = 1'b0;
        ovr_clr    = 1'b0;
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
